// File: rtl/pcm_frame_packer.sv
// rtl/pcm_frame_packer.sv - PCM sample to byte-stream framer feeding the SPI TX FIFO.
// Optional trailing XOR checksum byte per frame enabled by PCM_PACKER_CHECKSUM_EN.
module pcm_frame_packer #(
  parameter int         SAMPLES_PER_FRAME = 32,
  parameter logic [7:0] SYNC_WORD         = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pcm_in,
  input  logic        pcm_ready,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [7:0]  fifo_write_data,
  output logic [15:0] dropped_count,
  output logic        frame_active
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SEQ, S_LO, S_HI, S_CHK} state_t;

  localparam logic [7:0] LAST_IDX = 8'(SAMPLES_PER_FRAME - 1);

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_valid_q, hold_valid_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] dropped_q, dropped_d;
`ifdef PCM_PACKER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic capture;
  logic adv;
  logic last_byte;

  assign capture   = sync_q[1] & ~sync_q[2];
  assign adv       = (state_q != S_IDLE) && !fifo_full;
  assign last_byte = adv && (state_q == S_HI);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sync_q       <= 3'b000;
      hold_q       <= 16'h0000;
      hold_valid_q <= 1'b0;
      seq_q        <= 8'h00;
      idx_q        <= 8'h00;
      dropped_q    <= 16'h0000;
`ifdef PCM_PACKER_CHECKSUM_EN
      xor_q        <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      seq_q        <= seq_d;
      idx_q        <= idx_d;
      dropped_q    <= dropped_d;
`ifdef PCM_PACKER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (hold_valid_q) state_d = (idx_q == 8'h00) ? S_SYNC : S_LO;
      S_SYNC: if (adv) state_d = S_SEQ;
      S_SEQ:  if (adv) state_d = S_LO;
      S_LO:   if (adv) state_d = S_HI;
      S_HI: begin
        if (adv) begin
`ifdef PCM_PACKER_CHECKSUM_EN
          state_d = (idx_q == LAST_IDX) ? S_CHK : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_CHK:  if (adv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync_d       = {sync_q[1:0], pcm_ready};
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    seq_d        = seq_q;
    idx_d        = idx_q;
    dropped_d    = dropped_q;

    if (last_byte) begin
      hold_valid_d = 1'b0;
      if (idx_q == LAST_IDX) begin
        idx_d = 8'h00;
`ifndef PCM_PACKER_CHECKSUM_EN
        seq_d = seq_q + 8'd1;
`endif
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end
`ifdef PCM_PACKER_CHECKSUM_EN
    if (adv && (state_q == S_CHK)) seq_d = seq_q + 8'd1;
`endif

    // The hold slot frees up in the same cycle its HI byte leaves, so a
    // sample arriving then is still accepted.
    if (capture) begin
      if (!hold_valid_q || last_byte) begin
        hold_d       = pcm_in;
        hold_valid_d = 1'b1;
      end else if (dropped_q != 16'hFFFF) begin
        dropped_d = dropped_q + 16'd1;
      end
    end
  end

`ifdef PCM_PACKER_CHECKSUM_EN
  always_comb begin
    xor_d = xor_q;
    if (adv) begin
      case (state_q)
        S_SYNC:  xor_d = 8'h00;
        S_SEQ:   xor_d = seq_q;
        S_LO:    xor_d = xor_q ^ hold_q[7:0];
        S_HI:    xor_d = xor_q ^ hold_q[15:8];
        default: xor_d = xor_q;
      endcase
    end
  end
`endif

  always_comb begin
    fifo_write_data = 8'h00;
    case (state_q)
      S_SYNC:  fifo_write_data = SYNC_WORD;
      S_SEQ:   fifo_write_data = seq_q;
      S_LO:    fifo_write_data = hold_q[7:0];
      S_HI:    fifo_write_data = hold_q[15:8];
`ifdef PCM_PACKER_CHECKSUM_EN
      S_CHK:   fifo_write_data = xor_q;
`endif
      default: fifo_write_data = 8'h00;
    endcase
    fifo_wr_en    = adv;
    frame_active  = (state_q != S_IDLE) || (idx_q != 8'h00);
    dropped_count = dropped_q;
  end

endmodule
